// File: rtl/sobol_pkg.sv
// Shared constants, FSM state type and default direction numbers for the Sobol generator.
// Optional build macro used by the top level: SOBOL_SKIP_ZERO_EN.
package sobol_pkg;

    localparam int WIDTH = 32;
    localparam int IDX_W = 5;
    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // v[k] = 1 << (WIDTH-1-k): the van der Corput direction numbers
    function automatic logic [WIDTH-1:0] default_dir(input logic [IDX_W-1:0] k);
        logic [WIDTH-1:0] msb;
        msb = {1'b1, {(WIDTH-1){1'b0}}};
        return msb >> k;
    endfunction

endpackage

// File: rtl/sobol_seq_gen_trailing_ones.sv
// Trailing-ones counter: index of the lowest zero bit of n, selecting the direction number.
module sobol_seq_gen_trailing_ones
    import sobol_pkg::*;
(
    input  logic [WIDTH-1:0] n_i,
    output logic [IDX_W-1:0] c_o
);

    // Scan from MSB down so the lowest zero wins; all-ones is unreachable in use.
    always_comb begin
        c_o = '0;
        for (int i = WIDTH-1; i >= 0; i--) begin
            if (!n_i[i]) begin
                c_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sobol_seq_gen.sv
// Single-dimension Gray-code Sobol sample generator with a valid/ready output.
// Build macro SOBOL_SKIP_ZERO_EN suppresses the always-zero first sample x_0.
module sobol_seq_gen
    import sobol_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dir_we_i,
    input  logic [IDX_W-1:0] dir_addr_i,
    input  logic [WIDTH-1:0] dir_data_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_samples_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             busy_o,
    output logic             done_o
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [WIDTH-1:0] dir_q [WIDTH];
    logic [IDX_W-1:0] c;
    logic             hs;
    logic             last;
    logic [CNT_W-1:0] n_start;
    logic [WIDTH-1:0] x_start;

    sobol_seq_gen_trailing_ones u_tones (
        .n_i (n_q[WIDTH-1:0]),
        .c_o (c)
    );

    assign hs = (state_q == RUN) && out_ready_i;

`ifdef SOBOL_SKIP_ZERO_EN
    // x_1 = v[0]; forward a same-cycle write so it is not lost to the precompute.
    assign x_start = (dir_we_i && (dir_addr_i == '0)) ? dir_data_i : dir_q[0];
    assign n_start = CNT_W'(1);
    assign last    = (n_q == num_q);
`else
    assign x_start = '0;
    assign n_start = '0;
    assign last    = (n_q == (num_q - CNT_W'(1)));
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        n_d     = n_q;
        num_d   = num_q;
        case (state_q)
            IDLE: begin
                if (start_i && (num_samples_i != '0)) begin
                    state_d = RUN;
                    num_d   = num_samples_i;
                    n_d     = n_start;
                    x_d     = x_start;
                end
            end
            RUN: begin
                if (hs) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        x_d = x_q ^ dir_q[c];
                        n_d = n_q + CNT_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            n_q     <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            n_q     <= n_d;
            num_q   <= num_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < WIDTH; k++) begin
                dir_q[k] <= default_dir(IDX_W'(k));
            end
        end else if ((state_q == IDLE) && dir_we_i) begin
            dir_q[dir_addr_i] <= dir_data_i;
        end
    end

    assign out_valid_o = (state_q == RUN);
    assign out_data_o  = x_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);

endmodule
